// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the expression-string link.
// The transmitter and the string-checker FSM both import this package.
package expr_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_MUL  = 8'h2A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2
    } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Maps a decimal digit or an operator bit to its ASCII byte.
// When sel=1 the op bit chooses between '*' (1) and '+' (0).
module expr_char_enc
    import expr_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       op,
    input  logic       sel,
    output logic [7:0] code
);

    always_comb begin
        code = ASCII_0 + {4'h0, digit};
        if (sel) begin
            code = op ? ASCII_MUL : ASCII_PLUS;
        end
    end

endmodule

// File: rtl/expr_string_tx.sv
// Expression-string transmitter: serialises latched digits/operators as
// ASCII D{(+|*)D}, one byte per accepted beat, with registered outputs.
module expr_string_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       term_cnt,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    state_t                 state, state_nx;
    logic [CNT_W-1:0]       idx, idx_nx;
    logic [CNT_W-1:0]       n_q;
    logic [4*MAX_TERMS-1:0] digits_q;
    logic [MAX_TERMS-2:0]   ops_q;

    logic                   legal;
    logic                   load;
    logic                   beat;
    logic                   done_nx;
    logic                   err_nx;
    logic                   last_nx;
    logic [CNT_W-1:0]       n_src;
    logic [4*MAX_TERMS-1:0] digits_src;
    logic [MAX_TERMS-2:0]   ops_src;
    logic [3:0]             digit_sel;
    logic                   op_sel;
    logic [7:0]             code_nx;

    function automatic logic [3:0] pick_digit(input logic [4*MAX_TERMS-1:0] d,
                                              input logic [CNT_W-1:0]       i);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < MAX_TERMS; k++) begin
            if (i == CNT_W'(k)) r = d[4*k +: 4];
        end
        return r;
    endfunction

    function automatic logic pick_op(input logic [MAX_TERMS-2:0] o,
                                     input logic [CNT_W-1:0]     i);
        logic r;
        r = 1'b0;
        for (int k = 0; k < MAX_TERMS - 1; k++) begin
            if (i == CNT_W'(k)) r = o[k];
        end
        return r;
    endfunction

    // Only digits below the requested count are checked; the rest are don't-care.
    always_comb begin
        legal = 1'b1;
        if (term_cnt == '0 || term_cnt > CNT_W'(MAX_TERMS)) begin
            legal = 1'b0;
        end
        for (int k = 0; k < MAX_TERMS; k++) begin
            if (CNT_W'(k) < term_cnt && digits[4*k +: 4] > 4'd9) legal = 1'b0;
        end
    end

    assign beat = out_valid & out_ready;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        load     = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        load     = 1'b1;
                        idx_nx   = '0;
                        state_nx = DIGIT;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            DIGIT: begin
                if (beat) begin
                    if (idx == n_q - CNT_W'(1)) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = OP;
                    end
                end
            end
            OP: begin
                if (beat) begin
                    idx_nx   = idx + CNT_W'(1);
                    state_nx = DIGIT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are precomputed from next-cycle state so every output is a flop;
    // on a load the fresh inputs are encoded before they land in the latch.
    assign n_src      = load ? term_cnt : n_q;
    assign digits_src = load ? digits   : digits_q;
    assign ops_src    = load ? ops      : ops_q;
    assign digit_sel  = pick_digit(digits_src, idx_nx);
    assign op_sel     = pick_op(ops_src, idx_nx);
    assign last_nx    = (state_nx == DIGIT) && (idx_nx == n_src - CNT_W'(1));

    expr_char_enc u_enc (
        .digit (digit_sel),
        .op    (op_sel),
        .sel   (state_nx == OP),
        .code  (code_nx)
    );

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            idx       <= '0;
            n_q       <= '0;
            digits_q  <= '0;
            ops_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            if (load) begin
                n_q      <= term_cnt;
                digits_q <= digits;
                ops_q    <= ops;
            end
            out_valid <= (state_nx != IDLE);
            out_data  <= (state_nx != IDLE) ? code_nx : 8'h00;
            out_last  <= last_nx;
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_expr_string_tx.sv
// Scoreboard bench for expr_string_tx: stimulus queues expected bytes,
// a negedge monitor pops and compares them on every accepted beat.
module tb_expr_string_tx;

    localparam int MT = 8;
    localparam int CW = $clog2(MT + 1);

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   term_cnt = '0;
    logic [4*MT-1:0] digits = '0;
    logic [MT-2:0]   ops = '0;
    logic            out_ready = 1'b1;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err;

    expr_string_tx #(.MAX_TERMS(MT), .CNT_W(CW)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .term_cnt  (term_cnt),
        .digits    (digits),
        .ops       (ops),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      mon_e;
    int         n_vec = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    bit         stall_prev = 1'b0;
    logic [7:0] data_prev = '0;
    logic       last_prev = 1'b0;
    int         cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n, input logic [31:0] d, input logic [6:0] o, input bit push);
        logic [31:0] dv;
        logic [6:0]  ov;
        dv = d;
        ov = o;
        start    = 1'b1;
        term_cnt = CW'(n);
        digits   = d;
        ops      = o;
        if (push) begin
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{data: 8'h30 + {4'h0, dv[4*k +: 4]}, last: (k == n - 1)});
                if (k < n - 1) exp_q.push_back('{data: ov[k] ? 8'h2A : 8'h2B, last: 1'b0});
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!done && c < 60) begin
            tick();
            c++;
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_done: no done pulse within %0d cycles", c);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got %0h with no byte expected", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", out_data, mon_e.data);
                    check("beat_last", out_last, mon_e.last);
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero", {out_data, out_last}, 9'h000);
            end
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1'b1);
                check("stall_data_held", out_data, data_prev);
                check("stall_last_held", out_last, last_prev);
            end
            stall_prev = out_valid && !out_ready && clr_n;
            data_prev  = out_data;
            last_prev  = out_last;
        end
    end

    initial begin
        clr_n = 1'b0;
        repeat (2) tick();
        mon_en = 1'b1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        clr_n = 1'b1;
        tick();

        // single digit
        issue(1, 32'h7, 7'h0, 1'b1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 8'h37);
        check("t1_last", out_last, 1'b1);
        check("t1_busy", busy, 1'b1);
        wait_done(cyc);
        check("t1_done_cycles", cyc, 1);
        check("t1_busy_after", busy, 1'b0);
        tick();
        check("t1_done_one_cycle", done, 1'b0);

        // "1+2*3" at full rate
        issue(3, 32'h321, 7'b0000010, 1'b1);
        wait_done(cyc);
        check("t2_done_cycles", cyc, 5);
        tick();

        // same string, 3 stall cycles on the '+'
        issue(3, 32'h321, 7'b0000010, 1'b1);
        tick();
        out_ready = 1'b0;
        check("t3_stalled_byte", out_data, 8'h2B);
        repeat (3) tick();
        out_ready = 1'b1;
        wait_done(cyc);
        check("t3_done_cycles", cyc, 4);
        tick();

        // illegal loads
        issue(2, 32'hA3, 7'h0, 1'b0);
        check("t4_digit_err", err, 1'b1);
        check("t4_digit_valid", out_valid, 1'b0);
        check("t4_digit_busy", busy, 1'b0);
        tick();
        check("t4_err_one_cycle", err, 1'b0);
        issue(0, 32'h1, 7'h0, 1'b0);
        check("t4_n0_err", err, 1'b1);
        check("t4_n0_busy", busy, 1'b0);
        tick();
        issue(9, 32'h11111111, 7'h0, 1'b0);
        check("t4_n9_err", err, 1'b1);
        check("t4_n9_valid", out_valid, 1'b0);
        tick();
        // digits above N may be anything
        issue(2, 32'hFFFFFF45, 7'h7F, 1'b1);
        check("t4_ignored_hi_err", err, 1'b0);
        wait_done(cyc);
        check("t4_ignored_hi_cycles", cyc, 3);
        tick();

        // reset while the third byte is presented
        issue(4, 32'h4321, 7'h0, 1'b1);
        tick();
        tick();
        check("t5_third_byte", out_data, 8'h32);
        clr_n = 1'b0;
        tick();
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        exp_q.delete();
        clr_n = 1'b1;
        repeat (3) begin
            tick();
            check("t5_no_done", done, 1'b0);
            check("t5_no_bytes", out_valid, 1'b0);
        end
        issue(2, 32'h95, 7'b0000001, 1'b1);
        wait_done(cyc);
        check("t5_restart_cycles", cyc, 3);
        tick();

        // start while busy is ignored; start on the done cycle is taken
        issue(3, 32'h789, 7'b0000001, 1'b1);
        tick();
        start    = 1'b1;
        term_cnt = CW'(2);
        digits   = 32'h11;
        ops      = 7'h0;
        tick();
        start = 1'b0;
        check("t6_busy_start_no_err", err, 1'b0);
        wait_done(cyc);
        check("t6_first_cycles", cyc, 3);
        issue(2, 32'h21, 7'h0, 1'b1);
        check("t6_back_to_back_valid", out_valid, 1'b1);
        check("t6_back_to_back_data", out_data, 8'h31);
        wait_done(cyc);
        check("t6_second_cycles", cyc, 3);
        tick();

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
